// File: rtl/instr_encoder.sv
// Assembles RV32 R/I-type instruction words from handshaked requests, buffers them in a FIFO,
// and drains them as sequential instruction-memory writes. Optional macro: ENC_NOP_PAD_EN.
module instr_encoder #(
    parameter int                DEPTH     = 4,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [3:0]                 op_sel_i,
    input  logic [4:0]                 rd_i,
    input  logic [4:0]                 rs1_i,
    input  logic [4:0]                 rs2_i,
    input  logic [11:0]                imm_i,
    output logic                       wr_valid_o,
    input  logic                       wr_ready_i,
    output logic [ADDR_W-1:0]          waddr_o,
    output logic [31:0]                wdata_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       err_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;

    typedef enum logic [3:0] {
        OP_AND  = 4'd0,
        OP_XOR  = 4'd1,
        OP_SLL  = 4'd2,
        OP_ADD  = 4'd3,
        OP_SUB  = 4'd4,
        OP_MUL  = 4'd5,
        OP_ADDI = 4'd6,
        OP_SRAI = 4'd7
    } op_e;

    logic [31:0]       mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] waddr;
    logic              err;

    logic [31:0] enc_word;
    logic        illegal;
    logic        accept;
    logic        push;
    logic        pop;

    always_comb begin
        enc_word = '0;
        illegal  = 1'b0;
        case (op_e'(op_sel_i))
            OP_AND:  enc_word = {7'b0000000, rs2_i, rs1_i, 3'b111, rd_i, OPC_R};
            OP_XOR:  enc_word = {7'b0000000, rs2_i, rs1_i, 3'b100, rd_i, OPC_R};
            OP_SLL:  enc_word = {7'b0000000, rs2_i, rs1_i, 3'b001, rd_i, OPC_R};
            OP_ADD:  enc_word = {7'b0000000, rs2_i, rs1_i, 3'b000, rd_i, OPC_R};
            OP_SUB:  enc_word = {7'b0100000, rs2_i, rs1_i, 3'b000, rd_i, OPC_R};
            OP_MUL:  enc_word = {7'b0000001, rs2_i, rs1_i, 3'b000, rd_i, OPC_R};
            OP_ADDI: enc_word = {imm_i, rs1_i, 3'b000, rd_i, OPC_I};
            OP_SRAI: enc_word = {7'b0100000, imm_i[4:0], rs1_i, 3'b101, rd_i, OPC_I};
            default: begin
                illegal  = 1'b1;
`ifdef ENC_NOP_PAD_EN
                enc_word = 32'h0000_0013;
`else
                enc_word = '0;
`endif
            end
        endcase
    end

    assign ready_o    = (count != FULL_CNT);
    assign wr_valid_o = (count != '0);
    assign accept     = valid_i && ready_o;
    assign pop        = wr_valid_o && wr_ready_i;
`ifdef ENC_NOP_PAD_EN
    assign push       = accept;
`else
    assign push       = accept && !illegal;
`endif

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= enc_word;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            waddr  <= BASE_ADDR;
            err    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                waddr  <= waddr + ADDR_W'(4);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            err <= accept && illegal;
        end
    end

    assign wdata_o = mem[rd_ptr];
    assign waddr_o = waddr;
    assign count_o = count;
    assign err_o   = err;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: table-driven encodings plus handshake, full, illegal and reset sequences.
module tb_instr_encoder;

    logic        clk;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [3:0]  op_sel_i;
    logic [4:0]  rd_i;
    logic [4:0]  rs1_i;
    logic [4:0]  rs2_i;
    logic [11:0] imm_i;
    logic        wr_valid_o;
    logic        wr_ready_i;
    logic [31:0] waddr_o;
    logic [31:0] wdata_o;
    logic [2:0]  count_o;
    logic        err_o;

    instr_encoder #(
        .DEPTH(4),
        .ADDR_W(32),
        .BASE_ADDR(32'h0)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .op_sel_i(op_sel_i),
        .rd_i(rd_i),
        .rs1_i(rs1_i),
        .rs2_i(rs2_i),
        .imm_i(imm_i),
        .wr_valid_o(wr_valid_o),
        .wr_ready_i(wr_ready_i),
        .waddr_o(waddr_o),
        .wdata_o(wdata_o),
        .count_o(count_o),
        .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [10];
    logic [63:0] sb [$];
    logic [31:0] exp_addr;
    logic [63:0] mon_e;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Inputs change 2 time units after the active edge; outputs sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [11:0] imm);
        op_sel_i = op;
        rd_i     = rd;
        rs1_i    = rs1;
        rs2_i    = rs2;
        imm_i    = imm;
        valid_i  = 1'b1;
    endtask

    task automatic sb_push(input logic [31:0] word);
        sb.push_back({exp_addr, word});
        exp_addr = exp_addr + 32'd4;
    endtask

    task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [11:0] imm,
                        input logic [31:0] exp, input logic legal);
        int n;
        n = 0;
        drive(op, rd, rs1, rs2, imm);
        while (!ready_o && n < 20) begin
            step();
            n++;
        end
        if (!ready_o) begin
            chk("accept_timeout", 32'(ready_o), 32'd1);
        end else begin
            if (legal) sb_push(exp);
`ifdef ENC_NOP_PAD_EN
            else sb_push(32'h0000_0013);
`endif
            step();
        end
        valid_i = 1'b0;
    endtask

    task automatic send_vec(input int i);
        send(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].exp, 1'b1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || count_o != 3'd0) && n < 100) begin
            step();
            n++;
        end
        chk("drain_count", 32'(count_o), 32'd0);
        chk("drain_sb", 32'(sb.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_i && wr_valid_o && wr_ready_i) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", wdata_o, 32'hxxxx_xxxx);
            end else begin
                mon_e = sb.pop_front();
                chk("wdata", wdata_o, mon_e[31:0]);
                chk("waddr", waddr_o, mon_e[63:32]);
            end
        end
    end

    initial begin
        logic [2:0] c0;
        vecs[0] = '{4'd3, 5'd3,  5'd1,  5'd2,  12'h000, 32'h002081B3};
        vecs[1] = '{4'd4, 5'd3,  5'd1,  5'd2,  12'h000, 32'h402081B3};
        vecs[2] = '{4'd5, 5'd4,  5'd1,  5'd2,  12'h000, 32'h02208233};
        vecs[3] = '{4'd6, 5'd5,  5'd0,  5'd0,  12'hFFF, 32'hFFF00293};
        vecs[4] = '{4'd7, 5'd6,  5'd5,  5'd0,  12'h003, 32'h4032D313};
        vecs[5] = '{4'd0, 5'd1,  5'd2,  5'd3,  12'h000, 32'h003170B3};
        vecs[6] = '{4'd1, 5'd31, 5'd31, 5'd31, 12'h000, 32'h01FFCFB3};
        vecs[7] = '{4'd2, 5'd10, 5'd11, 5'd12, 12'h000, 32'h00C59533};
        vecs[8] = '{4'd7, 5'd7,  5'd8,  5'd0,  12'hFFF, 32'h41F45393};
        vecs[9] = '{4'd6, 5'd1,  5'd1,  5'd0,  12'h800, 32'h80008093};

        rst_i = 1'b0; valid_i = 1'b0; wr_ready_i = 1'b0;
        op_sel_i = '0; rd_i = '0; rs1_i = '0; rs2_i = '0; imm_i = '0;
        exp_addr = 32'h0;
        #2;
        step(); step();
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_wr_valid", 32'(wr_valid_o), 32'd0);
        chk("rst_waddr", waddr_o, 32'h0);
        chk("rst_err", 32'(err_o), 32'd0);
        rst_i = 1'b1;
        step();
        chk("rst_ready", 32'(ready_o), 32'd1);

        // first word latency and address advance
        wr_ready_i = 1'b1;
        send_vec(0);
        chk("lat_wr_valid", 32'(wr_valid_o), 32'd1);
        step();
        chk("lat_waddr_next", waddr_o, 32'h4);
        chk("lat_count", 32'(count_o), 32'd0);

        for (int i = 1; i < 10; i++) send_vec(i);
        wait_drain();

        // fill, hold a blocked request, then release
        wr_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) send_vec(i);
        chk("full_count", 32'(count_o), 32'd4);
        chk("full_ready", 32'(ready_o), 32'd0);
        drive(vecs[4].op, vecs[4].rd, vecs[4].rs1, vecs[4].rs2, vecs[4].imm);
        repeat (3) step();
        chk("held_count", 32'(count_o), 32'd4);
        chk("held_ready", 32'(ready_o), 32'd0);
        wr_ready_i = 1'b1;
        step();
        chk("full_pop_count", 32'(count_o), 32'd3);
        chk("full_pop_ready", 32'(ready_o), 32'd1);
        sb_push(vecs[4].exp);
        step();
        valid_i = 1'b0;
        chk("pushpop_count3", 32'(count_o), 32'd3);
        wait_drain();

        // simultaneous push and pop at count 2
        wr_ready_i = 1'b0;
        send_vec(5);
        send_vec(6);
        chk("two_count", 32'(count_o), 32'd2);
        drive(vecs[7].op, vecs[7].rd, vecs[7].rs1, vecs[7].rs2, vecs[7].imm);
        wr_ready_i = 1'b1;
        sb_push(vecs[7].exp);
        step();
        valid_i = 1'b0;
        chk("pushpop_count2", 32'(count_o), 32'd2);
        wait_drain();

        // illegal op
        wr_ready_i = 1'b0;
        c0 = count_o;
        send(4'd9, 5'd1, 5'd2, 5'd3, 12'h0, 32'h0, 1'b0);
        chk("illegal_err", 32'(err_o), 32'd1);
`ifdef ENC_NOP_PAD_EN
        chk("illegal_count", 32'(count_o), 32'(c0) + 32'd1);
`else
        chk("illegal_count", 32'(count_o), 32'(c0));
`endif
        step();
        chk("illegal_err_low", 32'(err_o), 32'd0);
        wr_ready_i = 1'b1;
        send_vec(8);
        wait_drain();

        // reset with buffered words
        wr_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) send_vec(i);
        chk("pre_rst_count", 32'(count_o), 32'd3);
        rst_i = 1'b0;
        step();
        sb.delete();
        exp_addr = 32'h0;
        chk("midrst_count", 32'(count_o), 32'd0);
        chk("midrst_wr_valid", 32'(wr_valid_o), 32'd0);
        chk("midrst_waddr", waddr_o, 32'h0);
        rst_i = 1'b1;
        step();
        chk("midrst_ready", 32'(ready_o), 32'd1);
        wr_ready_i = 1'b1;
        send_vec(9);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
